// File: rtl/vid_text_writer.sv
// Character-stream front end for the 18-bit text video memory: accepts glyphs and
// cursor commands, tracks an 80x60 cursor and read-modify-writes glyph fields.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a command; NEWLINE/HOME complete here in one cycle
// S_READ  | glyph word address presented, memory read in flight
// S_WRITE | merged word written back, cursor advances on exit
// S_CLEAR | zero-fill of the whole text area, one word per cycle
module vid_text_writer #(
   parameter int BASE_ADDR     = 256,
   parameter int WORDS_PER_ROW = 27,
   parameter int COLS          = 80,
   parameter int ROWS          = 60
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        char_valid,
   input  logic [1:0]  cmd,
   input  logic [5:0]  char_code,
   output logic        char_ready,
   output logic        mem_we,
   output logic [10:0] mem_addr,
   output logic [17:0] mem_din,
   input  logic [17:0] mem_dout,
   output logic [6:0]  cur_col,
   output logic [5:0]  cur_row,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   localparam logic [1:0] CMD_PUT     = 2'b00;
   localparam logic [1:0] CMD_NEWLINE = 2'b01;
   localparam logic [1:0] CMD_CLEAR   = 2'b10;
   localparam logic [1:0] CMD_HOME    = 2'b11;

   localparam logic [10:0] CLR_LAST = 11'(ROWS * WORDS_PER_ROW - 1);
   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);

   logic [1:0]  state;
   logic [5:0]  code_q;
   logic [1:0]  field_q;
   logic [10:0] addr_q;
   logic [10:0] clr_cnt;

   logic        accept;
   logic [10:0] row_base;
   logic [10:0] cur_addr;
   logic [1:0]  cur_field;
   logic [5:0]  next_row;
   logic [6:0]  adv_col;
   logic [5:0]  adv_row;
   logic [17:0] merged;

   assign char_ready = (state == S_IDLE) && !CLR;
   assign accept     = char_valid && char_ready;
   assign busy       = (state != S_IDLE);
   assign mem_addr   = addr_q;

   // 11-bit arithmetic throughout: the largest cursor address is 1875
   assign row_base  = 11'(BASE_ADDR) + 11'(cur_row) * 11'(WORDS_PER_ROW);
   assign cur_addr  = row_base + 11'(cur_col / 7'd3);
   assign cur_field = 2'(cur_col % 7'd3);
   assign next_row  = (cur_row == ROW_LAST) ? 6'd0 : cur_row + 6'd1;

   always_comb begin
      adv_col = cur_col + 7'd1;
      adv_row = cur_row;
      if (cur_col == COL_LAST) begin
         adv_col = 7'd0;
         adv_row = next_row;
      end
   end

   // Field 0 sits in the top bits so glyphs read left-to-right in the word
   always_comb begin
      merged = mem_dout;
      case (field_q)
         2'd0:    merged[17:12] = code_q;
         2'd1:    merged[11:6]  = code_q;
         default: merged[5:0]   = code_q;
      endcase
   end

   assign mem_we  = (state == S_WRITE) || (state == S_CLEAR);
   assign mem_din = (state == S_WRITE) ? merged : 18'd0;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= S_IDLE;
         code_q  <= 6'd0;
         field_q <= 2'd0;
         addr_q  <= 11'd0;
         clr_cnt <= 11'd0;
         cur_col <= 7'd0;
         cur_row <= 6'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (cmd)
                     CMD_PUT: begin
                        code_q  <= char_code;
                        field_q <= cur_field;
                        addr_q  <= cur_addr;
                        state   <= S_READ;
                     end
                     CMD_NEWLINE: begin
                        cur_col <= 7'd0;
                        cur_row <= next_row;
                     end
                     CMD_CLEAR: begin
                        clr_cnt <= 11'd0;
                        addr_q  <= 11'(BASE_ADDR);
                        state   <= S_CLEAR;
                     end
                     default: begin
                        cur_col <= 7'd0;
                        cur_row <= 6'd0;
                     end
                  endcase
               end
            end
            S_READ: state <= S_WRITE;
            S_WRITE: begin
               cur_col <= adv_col;
               cur_row <= adv_row;
               state   <= S_IDLE;
            end
            default: begin
               if (clr_cnt == CLR_LAST) begin
                  cur_col <= 7'd0;
                  cur_row <= 6'd0;
                  state   <= S_IDLE;
               end else begin
                  clr_cnt <= clr_cnt + 11'd1;
                  addr_q  <= addr_q + 11'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/vid_text_writer.md
# vid_text_writer

Character-stream front end for the 18-bit text video memory. Accepts glyph codes and cursor commands over a valid/ready handshake, maintains an 80x60 cursor, and writes into the video memory through a port with one-cycle read latency. Each glyph write is a read-modify-write. The display renderer reads the same memory on its other port, so this block is the producer for that renderer.

## Interface
Parameters:
- BASE_ADDR, 256: word address of row 0, column 0.
- WORDS_PER_ROW, 27: memory words per text row (3 glyphs per word).
- COLS, 80: visible columns, 0..79.
- ROWS, 60: text rows, 0..59.

Ports:
- CLK  in  1  single clock. Synchronous reset is active-high.
- CLR  in  1  synchronous reset, active-high.
- char_valid  in  1  a command or character is offered.
- cmd  in  2  command code: 00 PUT, 01 NEWLINE, 10 CLEAR, 11 HOME.
- char_code  in  6  glyph code for PUT. Ignored for other commands.
- char_ready  out  1  block can accept. Transfer occurs when valid & ready at a CLK edge.
- mem_we  out  1  write enable for the video memory port.
- mem_addr  out  11  video memory word address.
- mem_din  out  18  write data.
- mem_dout  in  18  read data. Valid in the cycle after mem_addr is presented.
- cur_col  out  7  current cursor column, 0..79.
- cur_row  out  6  current cursor row, 0..59.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, READ, WRITE, CLEAR.
- Cursor address: BASE_ADDR + cur_row*27 + cur_col/3. All arithmetic is at least 11 bits wide with no truncation; the maximum value is 256+59*27+26 = 1875.
- Field select uses cur_col%3:
  - 0 → bits [17:12]
  - 1 → bits [11:6]
  - 2 → bits [5:0]
- IDLE:
  - char_ready=1.
  - On a transfer, cmd is decoded.
- PUT:
  - Latch char_code, the address and the field, then go to READ.
  - READ: mem_addr = latched address, mem_we=0. Go to WRITE.
  - WRITE: mem_we=1 at the same address. mem_din = mem_dout with the selected 6-bit field replaced by char_code; the other two fields are preserved bit-exact.
  - WRITE then advances the cursor and returns to IDLE.
- Cursor advance:
  - col+1.
  - If col was 79: col=0, row+1.
  - If row was 59: row=0. There is no scrolling.
- NEWLINE: col=0, row+1 with wrap 59→0. Completes in one cycle with no memory access; the state stays IDLE.
- HOME: col=0, row=0. One cycle, no memory access.
- CLEAR:
  - Enter the CLEAR state with an internal counter at 0.
  - Each cycle: mem_we=1, mem_addr = BASE_ADDR + counter, mem_din = 0.
  - After the write at counter = 1619 (address 1875): cursor goes to 0,0 and the state goes to IDLE.
- Column 80 (the 81st field of each row) is never written by PUT. CLEAR zeroes it.
- Outside the WRITE and CLEAR states, mem_we=0 and mem_din=0. mem_addr holds its last value.

## Timing
- Reset (CLR high at an edge), state = IDLE and:
  - mem_we=0, mem_addr=0, mem_din=0
  - cur_col=0, cur_row=0
  - busy=0
  - char_ready=0 while CLR is high, 1 in the first cycle after CLR falls.
- PUT accepted at edge t0:
  - READ during t0..t1.
  - WRITE during t1..t2; the memory commits at t2.
  - Cursor updates at t2; char_ready rises after t2.
  - Throughput: one PUT per 3 cycles.
- NEWLINE and HOME: cursor updates at the accepting edge, and char_ready stays high. Back-to-back transfers are allowed every cycle.
- CLEAR accepted at t0:
  - Writes occur at edges t1..t1620.
  - Cursor is at 0,0 and char_ready=1 after t1620.
- char_ready is low in READ, WRITE and CLEAR. valid held high during busy is not consumed.
- CLR mid-operation: aborts immediately. There is no further write; a PUT in READ never writes, and a partial CLEAR is left as-is. Cursor goes to 0,0.
- char_code and cmd are sampled only at the accepting edge. Changes afterwards have no effect.

## Test plan
- Reset, memory word 256 = 0x3FFFF, PUT code 0x05 → write at addr 256 with din=0x05FFF. Cursor becomes 0,1 three cycles after accept.
- Three PUTs 0x01, 0x02, 0x03 from 0,0 → word 256 ends as 0x01083. Cursor ends at 0,3.
- Cursor at row 59, col 79, PUT 0x0A → write addr 1875, field [11:6]. Cursor wraps to 0,0.
- Cursor at 12,40, NEWLINE then HOME on consecutive cycles:
  - after the NEWLINE edge: 13,0
  - after the HOME edge: 0,0
  - no mem_we pulses
- CLEAR → exactly 1620 consecutive mem_we pulses at addresses 256..1875 with din=0. char_ready is low throughout, then goes high.
- CLR asserted in the READ cycle of a PUT → no mem_we. Outputs are at reset values, and char_ready=1 one cycle after CLR falls.
